// File: rtl/cic_interp_if.sv
// Sample-stream bundle between the CIC interpolator core and its neighbours:
// output-rate strobe in, input-rate request out, sample in, full-precision result out.
interface cic_interp_if #(
    parameter int bw         = 16,
    parameter int maxbitgain = 21
);
    localparam int W = bw + maxbitgain;

    logic                  strobe_out;
    logic                  strobe_in;
    logic signed [bw-1:0]  signal_in;
    logic signed [W-1:0]   signal_out;

    modport master (
        output strobe_out,
        output signal_in,
        input  strobe_in,
        input  signal_out
    );

    modport slave (
        input  strobe_out,
        input  signal_in,
        output strobe_in,
        output signal_out
    );
endinterface

// File: rtl/cic_interp_core.sv
// Four-stage CIC interpolator: combs at the input rate, zero-stuffing, then
// integrators at the output-strobe rate; also derives the input-rate request.
module cic_interp_core #(
    parameter int bw         = 16,
    parameter int N          = 4,
    parameter int maxbitgain = 21
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           enable,
    input  logic [7:0]     rate,
    cic_interp_if.slave    bus
);
    localparam int W = bw + maxbitgain;

    logic        [6:0]   cnt;
    logic                pending;
    logic signed [W-1:0] comb_reg;
    logic signed [W-1:0] d     [N];
    logic signed [W-1:0] integ [N];
    logic signed [W-1:0] x     [N+1];
    logic signed [W-1:0] u;
    logic                take;

    // Only R = 1..128 is supported, so the ratio MSB is never used.
    logic unused_rate_msb;
    assign unused_rate_msb = rate[7];

    assign take          = enable & bus.strobe_out & (cnt == 7'd0);
    assign bus.strobe_in = take;
    assign bus.signal_out = integ[N-1];

    // NOTE: every variable driven here gets a value on every path before use,
    // otherwise synthesis would infer a latch to hold the old value.
    always_comb begin
        x[0] = {{maxbitgain{bus.signal_in[bw-1]}}, bus.signal_in};
        for (int k = 0; k < N; k++) begin
            x[k+1] = x[k] - d[k];
        end
        u = pending ? comb_reg : '0;
    end

    // NOTE: the delay/integrator arrays are plain flops, not RAM, so they are
    // cleared element by element on both the async reset and the enable clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            pending  <= 1'b0;
            comb_reg <= '0;
            for (int k = 0; k < N; k++) begin
                d[k]     <= '0;
                integ[k] <= '0;
            end
        end else if (!enable) begin
            cnt      <= '0;
            pending  <= 1'b0;
            comb_reg <= '0;
            for (int k = 0; k < N; k++) begin
                d[k]     <= '0;
                integ[k] <= '0;
            end
        end else if (bus.strobe_out) begin
            // NOTE: non-blocking assignments make every integrator add its
            // neighbour's pre-update value, which is the cascade we want.
            integ[0] <= integ[0] + u;
            for (int k = 1; k < N; k++) begin
                integ[k] <= integ[k] + integ[k-1];
            end

            if (take) begin
                cnt      <= rate[6:0];
                pending  <= 1'b1;
                comb_reg <= x[N];
                for (int k = 0; k < N; k++) begin
                    d[k] <= x[k];
                end
            end else begin
                cnt     <= cnt - 7'd1;
                pending <= 1'b0;
            end
        end
    end
endmodule

// File: doc/cic_interp_core.md
# cic_interp_core

Four-stage CIC interpolator datapath for the transmit chain. It sits directly upstream of the interpolation bit-gain shifter. It accepts bw-bit samples at the low input rate, runs them through four combs, then zero-stuffs them and feeds four integrators at the output-strobe rate. It drives the full-precision bw+maxbitgain-bit result to the shifter. It also generates the input-rate sample request from the output-rate strobe using an internal decimating counter.

## Interface
- `bw`, 16: input sample width (two's complement)
- `N`, 4: number of comb and integrator stages; only 4 is supported
- `maxbitgain`, 21: worst-case bit growth (N-1)·log2(128); internal and output width is bw+maxbitgain

Ports:
- `clock`  in  1  single clock for all logic
- `reset`  in  1  asynchronous, active-low; low clears all state immediately
- `enable`  in  1  high = run; low = synchronous clear of all state
- `rate`  in  8  interpolation ratio minus one (0..127 → R = 1..128)
- `strobe_out`  in  1  output-rate sample strobe, one cycle wide
- `strobe_in`  out  1  input sample request/accept, one cycle wide
- `signal_in`  in  bw  input sample; must be valid in any cycle where strobe_in is high
- `signal_out`  out  bw+maxbitgain  last integrator register (full precision)

## Operation
- **Arithmetic width.** All comb delays, comb_reg and integrators are W = bw+maxbitgain bits. signal_in is sign-extended to W bits. Add and subtract wrap modulo 2^W; the wrap is intentional and is exact for CIC.
- **Rate counter (cnt, 7 bits).**
  - strobe_in = enable & strobe_out & (cnt == 0).
  - On strobe_in, cnt is loaded with rate[6:0].
  - On any other strobe_out, cnt decrements.
  - rate is sampled only at reload, so a mid-run change takes effect at the next input sample.
  - rate[7] is ignored.
- **Combs (on strobe_in only).**
  - x0 = sext(signal_in); x(k+1) = x(k) − d(k), where d(k) is the delay register of stage k, k = 0..3.
  - On strobe_in: d(k) <= x(k); comb_reg <= x4; pending <= 1.
- **Integrators (on strobe_out only).**
  - u = pending ? comb_reg : 0. This is the zero-stuffing: exactly one nonzero input per R output strobes.
  - i1 <= i1 + u; i2 <= i2 + i1; i3 <= i3 + i2; i4 <= i4 + i3. All right-hand sides use pre-update values.
  - pending is cleared on the strobe_out where it is consumed. If that cycle is also a strobe_in (always the case when R = 1), set wins.
  - comb_reg is read before update: the sample taken at a strobe_in is consumed at the following strobe_out.
- **Output.** signal_out = i4 (registered).
- **DC gain.** R^(N−1) = R³ ≤ 2^21, so the output never exceeds W bits for in-range inputs.

## Timing
- **Reset values.** strobe_in = 0, signal_out = 0, cnt = 0, pending = 0, all d/comb_reg/i registers = 0. The first strobe_out after reset, with enable high, produces strobe_in.
- **strobe_in** is combinational from strobe_out, cnt and enable, and is coincident with strobe_out. Upstream must present signal_in in that same cycle.
- **Latency.** A sample accepted at strobe_out event n first affects signal_out after strobe_out event n+4, i.e. it is visible the cycle after that edge.
- **Cycles without strobe_out** hold all state.
- **enable low.** Takes effect at the next clock edge: all registers are cleared and strobe_in is forced low. Resuming behaves exactly like post-reset.
- **reset asserted mid-stream** clears everything asynchronously. There are no partial-sample artefacts after release.
- **Strobe spacing.** Back-to-back strobe_out every cycle is legal at any rate.

## Test plan
- **Impulse, rate=3, strobe_out every cycle.** Drive signal_in = 1 at the first strobe_in and 0 at all later ones. Required: signal_out on successive strobes starting 4 strobes later is 1, 4, 10, 20, 31, 40, 44, 40, 31, 20, 10, 4, 1, then 0 forever. strobe_in is high on every 4th strobe_out.
- **DC, rate=127, signal_in = 1000 constant, strobe_out every 3rd cycle.** Required: signal_out settles to 2 097 152 000 (1000·2^21). strobe_in fires once per 128 strobes.
- **Negative full scale, rate=127, signal_in = −32768.** Required: settles to −2^36 = −68 719 476 736 with no wrap.
- **Rate=0 (R = 1), ramp input 0, 1, 2, ….** Required: strobe_in high on every strobe_out. Output equals the input passed through the 4-comb/4-integrator identity (R³ = 1), delayed by 4 strobes.
- **Rate change and enable drop.** Switch rate 7 → 15 mid-block. Required: the current 8-strobe period completes, then the period becomes 16. Then drop enable for 1 cycle. Required: the next edge zeroes signal_out and strobe_in, and the first strobe_out after re-enable produces strobe_in.
- **Asynchronous reset mid-impulse.** Assert reset low between clock edges. Required: signal_out = 0 immediately, with no clock edge needed. After release, a fresh impulse reproduces the full 13-tap response.
